// File: rtl/bram_read_streamer_if.sv
// Port bundle for bram_read_streamer: request, BRAM port-B read path and output stream.
// master = streamer side, slave = the environment (request source, BRAM, stream sink).
interface bram_read_streamer_if #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 256
);
  localparam int ADDR_W = $clog2(RAM_DEPTH);

  // request
  logic                 start_in;
  logic [ADDR_W-1:0]    base_addr_in;
  logic [ADDR_W:0]      len_in;
  logic                 busy_out;
  logic                 done_out;
  // BRAM port B
  logic                 enb_out;
  logic [ADDR_W-1:0]    addrb_out;
  logic [RAM_WIDTH-1:0] dob_in;
  // output stream
  logic [RAM_WIDTH-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 last_out;

  modport master (
    input  start_in, base_addr_in, len_in, dob_in, ready_in,
    output busy_out, done_out, enb_out, addrb_out, data_out, valid_out, last_out
  );

  modport slave (
    output start_in, base_addr_in, len_in, dob_in, ready_in,
    input  busy_out, done_out, enb_out, addrb_out, data_out, valid_out, last_out
  );
endinterface

// File: rtl/bram_read_streamer.sv
// Reads a contiguous, wrapping address range from a BRAM read port (1-cycle
// registered read) and presents it as a valid/ready stream. A 2-entry output
// FIFO absorbs the read latency; reads are only issued when the FIFO is
// guaranteed room for the returning word, so backpressure never loses data.
module bram_read_streamer #(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 256
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  bram_read_streamer_if.master  bus
);
  localparam int ADDR_W = $clog2(RAM_DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  typedef struct packed {
    logic                 last;
    logic [RAM_WIDTH-1:0] data;
  } entry_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  issued_q;
  logic              inflight_q;       // a read was issued last cycle; dob_in is valid now
  logic              inflight_last_q;  // that read was the final index of the request

  entry_t            fifo_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        count_q;

  entry_t            head;
  logic              pop, push, enb, issue_last, accept;
  logic [2:0]        occ;

  assign head   = fifo_q[rd_ptr_q];
  assign pop    = (count_q != 2'd0) && bus.ready_in;
  assign push   = inflight_q;
  assign accept = (state_q == IDLE) && bus.start_in;

  // Occupancy after this cycle's pop, counting the word still on its way back.
  // pop implies count_q >= 1, so this never underflows.
  assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

  // One read per cycle while words remain and the returning word is sure to fit.
  assign enb        = (state_q == RUN) && (issued_q < len_q) && (occ < 3'd2);
  assign issue_last = (issued_q == len_q - CNT_W'(1));

  assign bus.enb_out   = enb;
  assign bus.addrb_out = base_q + issued_q[ADDR_W-1:0];  // natural wrap modulo RAM_DEPTH
  assign bus.valid_out = (count_q != 2'd0);
  assign bus.data_out  = head.data;
  assign bus.last_out  = bus.valid_out && head.last;
  assign bus.busy_out  = (state_q == RUN);
  assign bus.done_out  = (state_q == DONE);

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: zero-length requests go straight to DONE; RUN ends when the last word leaves.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start_in) state_d = (bus.len_in == '0) ? DONE : RUN;
      RUN:  if (pop && head.last) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and read issue counter; start is ignored outside IDLE.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      base_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      inflight_q      <= enb;
      inflight_last_q <= enb && issue_last;
      if (accept) begin
        base_q   <= bus.base_addr_in;
        len_q    <= bus.len_in;
        issued_q <= '0;
      end else if (enb) begin
        issued_q <= issued_q + CNT_W'(1);
      end
    end
  end

  // Output FIFO: capture the returning BRAM word, release the head on handshake.
  // Issue gating keeps count_q <= 2, so a push never finds the FIFO full.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{last: inflight_last_q, data: bus.dob_in};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_read_streamer.sv
// Bench for bram_read_streamer: table of directed requests plus random requests
// with random backpressure, checked against a stream/address model derived
// from the request (base, len) and the bench's own copy of the RAM.
module tb_bram_read_streamer;
  localparam int W  = 32;
  localparam int D  = 256;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bram_read_streamer_if #(.RAM_WIDTH(W), .RAM_DEPTH(D)) bus ();

  bram_read_streamer #(.RAM_WIDTH(W), .RAM_DEPTH(D)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  // BRAM port-B model: registered read, data valid the cycle after enb.
  logic [W-1:0] ram [D];
  always @(posedge clk) if (bus.enb_out) bus.dob_in <= ram[bus.addrb_out];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_enb"},   bus.enb_out,   0);
    chk({tag, "_addrb"}, bus.addrb_out, 0);
    chk({tag, "_data"},  bus.data_out,  0);
    chk({tag, "_valid"}, bus.valid_out, 0);
    chk({tag, "_last"},  bus.last_out,  0);
    chk({tag, "_busy"},  bus.busy_out,  0);
    chk({tag, "_done"},  bus.done_out,  0);
  endtask

  // Runs one request starting next cycle (cycle 0 = start_in high). mode 0: ready
  // low in cycles whose bit is set in stall_mask; mode 1: random ready.
  // exp_done < 0 means the done cycle is only checked relative to the last transfer.
  task automatic run_req(input int base, input int len, input int mode,
                         input logic [31:0] stall_mask, input int exp_done,
                         input int restart_cyc);
    int nenb, npop, last_xfer, budget, c;
    logic got_last, pv, pr, pl, finished;
    logic [W-1:0] pd;
    nenb = 0; npop = 0; last_xfer = -1; got_last = 0;
    pv = 0; pr = 1; pl = 0; pd = '0; finished = 0;
    budget = 10 * len + 100;
    for (c = 0; c <= budget; c++) begin
      @(posedge clk); #1;
      if (c == 0) begin
        bus.start_in = 1'b1;
        bus.base_addr_in = base[AW-1:0];
        bus.len_in = len[AW:0];
      end else if (c == restart_cyc) begin
        bus.start_in = 1'b1;
        bus.base_addr_in = AW'(base + 77);
        bus.len_in = 9'd3;
      end else begin
        bus.start_in = 1'b0;
      end
      if (mode == 1) bus.ready_in = ($urandom_range(0, 9) < 7);
      else           bus.ready_in = (c < 32) ? !stall_mask[c] : 1'b1;
      @(negedge clk);
      // read issue: addresses walk base, base+1, ... modulo depth
      if (bus.enb_out) begin
        chk("enb_addr", bus.addrb_out, (base + nenb) % D);
        nenb++;
      end
      chk("busy", bus.busy_out, (len > 0) && (c >= 1) && !got_last);
      chk("done", bus.done_out, (len == 0) ? (c == 1) : (got_last && c == last_xfer + 1));
      if (pv && !pr) begin
        chk("hold_valid", bus.valid_out, 1);
        chk("hold_data", bus.data_out, pd);
        chk("hold_last", bus.last_out, pl);
      end
      if (bus.valid_out && bus.ready_in) begin
        if (npop < len) begin
          chk("data", bus.data_out, ram[(base + npop) % D]);
          chk("last", bus.last_out, npop == len - 1);
        end else begin
          chk("extra_word", 1, 0);
        end
        npop++;
        if (npop == len) begin
          got_last = 1;
          last_xfer = c;
        end
      end
      chk("occupancy", (nenb - npop) <= 2, 1);
      pv = bus.valid_out; pr = bus.ready_in; pd = bus.data_out; pl = bus.last_out;
      if ((len == 0 && c == 1) || (got_last && c == last_xfer + 1)) begin
        finished = 1;
        break;
      end
    end
    if (!finished) begin
      total++; bad++;
      $display("FAIL timeout: base=%0d len=%0d got %0d words want %0d", base, len, npop, len);
      rst = 1'b1; #3; rst = 1'b0;
    end else begin
      chk("enb_count", nenb, len);
      chk("word_count", npop, len);
      if (exp_done >= 0) chk("done_cycle", c, exp_done);
    end
  endtask

  typedef struct {
    int          base;
    int          len;
    logic [31:0] mask;
    int          exp_done;
    int          restart;
  } vec_t;

  vec_t vt [7];

  initial begin
    vt[0] = '{10,  4,   32'h0,  7,   -1};  // basic stream
    vt[1] = '{10,  4,   32'h38, 10,  -1};  // ready low cycles 3..5
    vt[2] = '{254, 4,   32'h0,  7,   -1};  // address wrap 255 -> 0
    vt[3] = '{0,   0,   32'h0,  1,   -1};  // zero length
    vt[4] = '{10,  4,   32'h0,  7,   2};   // start while running is ignored
    vt[5] = '{200, 256, 32'h0,  259, -1};  // full-depth request
    vt[6] = '{5,   1,   32'h0,  4,   -1};  // single word

    for (int i = 0; i < D; i++) ram[i] = $urandom;
    bus.start_in = 0; bus.base_addr_in = '0; bus.len_in = '0;
    bus.ready_in = 1; bus.dob_in = '0;

    rst = 1'b1;
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    for (int i = 0; i < 7; i++)
      run_req(vt[i].base, vt[i].len, 0, vt[i].mask, vt[i].exp_done, vt[i].restart);

    // Reset mid-stream, asserted between clock edges.
    @(posedge clk); #1;
    bus.start_in = 1; bus.base_addr_in = 8'd20; bus.len_in = 9'd8; bus.ready_in = 1;
    @(posedge clk); #1;
    bus.start_in = 0;
    repeat (3) @(posedge clk);
    #2; rst = 1'b1; #1;
    check_all_zero("mid_reset");
    repeat (2) begin
      @(negedge clk);
      chk("reset_no_done", bus.done_out, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_done", bus.done_out, 0);
    chk("post_reset_valid", bus.valid_out, 0);
    run_req(10, 4, 0, 32'h0, 7, -1);

    // Random requests with random backpressure.
    for (int n = 0; n < 30; n++) begin
      int b, l, r;
      b = $urandom_range(0, D - 1);
      r = $urandom_range(0, 9);
      l = (r == 0) ? 0 : (r == 1) ? D : $urandom_range(1, 24);
      run_req(b, l, 1, 32'h0, -1, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
